// File: rtl/mc_controller.sv
// Multicycle RV32I control FSM: Moore-style sequencing of fetch/decode/execute/writeback.
// Optional retired-instruction counter enabled by defining MC_INSTRET_EN.
module mc_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  op,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        Zero,
  input  logic        Lt,
  input  logic        Ltu,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ImmSrc,
  output logic [3:0]  ALUControl,
  output logic        RegWrite,
  output logic        Illegal,
  output logic [31:0] InstRet
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMREAD  = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWRITE = 4'd5;
  localparam logic [3:0] EXECR    = 4'd6;
  localparam logic [3:0] EXECI    = 4'd7;
  localparam logic [3:0] ALUWB    = 4'd8;
  localparam logic [3:0] BRANCH   = 4'd9;
  localparam logic [3:0] JAL      = 4'd10;
  localparam logic [3:0] JALR     = 4'd11;
  localparam logic [3:0] JALRPC   = 4'd12;
  localparam logic [3:0] LUI      = 4'd13;
  localparam logic [3:0] AUIPC    = 4'd14;

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic       w_taken;
  logic [3:0] w_alu_op;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = FETCH;
    case (r_state)
      FETCH:  w_next = DECODE;
      DECODE: begin
        case (op)
          7'b0000011, 7'b0100011: w_next = MEMADR;
          7'b0110011:             w_next = EXECR;
          7'b0010011:             w_next = EXECI;
          7'b1100011:             w_next = BRANCH;
          7'b1101111:             w_next = JAL;
          7'b1100111:             w_next = JALR;
          7'b0110111:             w_next = LUI;
          7'b0010111:             w_next = AUIPC;
          default:                w_next = FETCH;
        endcase
      end
      MEMADR:                   w_next = op[5] ? MEMWRITE : MEMREAD;
      MEMREAD:                  w_next = MEMWB;
      EXECR, EXECI:             w_next = ALUWB;
      JAL, JALRPC, LUI, AUIPC:  w_next = ALUWB;
      JALR:                     w_next = JALRPC;
      default:                  w_next = FETCH;
    endcase
  end

  always_comb begin
    w_taken = 1'b0;
    case (funct3)
      3'b000:  w_taken = Zero;
      3'b001:  w_taken = !Zero;
      3'b100:  w_taken = Lt;
      3'b101:  w_taken = !Lt;
      3'b110:  w_taken = Ltu;
      3'b111:  w_taken = !Ltu;
      default: w_taken = 1'b0;
    endcase
  end

  // funct7b5 selects sub only for register-register ops; shifts use it in both forms
  always_comb begin
    w_alu_op = 4'd0;
    case (funct3)
      3'b000:  w_alu_op = (r_state == EXECR && funct7b5) ? 4'd1 : 4'd0;
      3'b001:  w_alu_op = 4'd7;
      3'b010:  w_alu_op = 4'd5;
      3'b011:  w_alu_op = 4'd6;
      3'b100:  w_alu_op = 4'd4;
      3'b101:  w_alu_op = funct7b5 ? 4'd9 : 4'd8;
      3'b110:  w_alu_op = 4'd3;
      default: w_alu_op = 4'd2;
    endcase
  end

  always_comb begin
    case (op)
      7'b0100011:             ImmSrc = 3'd1;
      7'b1100011:             ImmSrc = 3'd2;
      7'b1101111:             ImmSrc = 3'd3;
      7'b0110111, 7'b0010111: ImmSrc = 3'd4;
      default:                ImmSrc = 3'd0;
    endcase
  end

  always_comb begin
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    ResultSrc  = 2'd0;
    ALUSrcA    = 2'd0;
    ALUSrcB    = 2'd0;
    ALUControl = 4'd0;
    RegWrite   = 1'b0;
    Illegal    = 1'b0;
    case (r_state)
      FETCH: begin
        IRWrite = 1'b1; ALUSrcB = 2'd2; ResultSrc = 2'd2; PCWrite = 1'b1;
      end
      DECODE: begin
        ALUSrcA = 2'd1; ALUSrcB = 2'd1;
        case (op)
          7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
          7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111: Illegal = 1'b0;
          default: Illegal = 1'b1;
        endcase
      end
      MEMADR:   begin ALUSrcA = 2'd2; ALUSrcB = 2'd1; end
      MEMREAD:  AdrSrc = 1'b1;
      MEMWB:    begin ResultSrc = 2'd1; RegWrite = 1'b1; end
      MEMWRITE: begin AdrSrc = 1'b1; MemWrite = 1'b1; end
      EXECR:    begin ALUSrcA = 2'd2; ALUControl = w_alu_op; end
      EXECI:    begin ALUSrcA = 2'd2; ALUSrcB = 2'd1; ALUControl = w_alu_op; end
      ALUWB:    RegWrite = 1'b1;
      BRANCH:   begin ALUSrcA = 2'd2; ALUControl = 4'd1; PCWrite = w_taken; end
      JAL:      begin ALUSrcA = 2'd1; ALUSrcB = 2'd2; PCWrite = 1'b1; end
      JALR:     begin ALUSrcA = 2'd2; ALUSrcB = 2'd1; end
      JALRPC:   begin ALUSrcA = 2'd1; ALUSrcB = 2'd2; PCWrite = 1'b1; end
      LUI:      begin ALUSrcA = 2'd3; ALUSrcB = 2'd1; end
      AUIPC:    begin ALUSrcA = 2'd1; ALUSrcB = 2'd1; end
      default:  ALUControl = 4'd0;
    endcase
    // state is already FETCH during reset; suppress its strobes until release
    if (!reset) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      Illegal  = 1'b0;
    end
  end

`ifdef MC_INSTRET_EN
  logic [31:0] r_instret;
  logic        w_retire;

  // entering FETCH from DECODE means an illegal opcode, which does not retire
  assign w_retire = (r_state != FETCH) && (r_state != DECODE) && (w_next == FETCH);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        r_instret <= 32'd0;
    else if (w_retire) r_instret <= r_instret + 32'd1;
  end

  assign InstRet = r_instret;
`else
  assign InstRet = 32'd0;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: per-cycle control vectors for each instruction class.
module tb_mc_controller;
  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5, Zero, Lt, Ltu;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0]  ImmSrc;
  logic [3:0]  ALUControl;
  logic [31:0] InstRet;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] exp_ret = 32'd0;

  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .Lt(Lt), .Ltu(Ltu), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .RegWrite(RegWrite), .Illegal(Illegal),
    .InstRet(InstRet)
  );

  always #5 clk = ~clk;

  // {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,RegWrite,Illegal}
  localparam logic [11:0] V_FETCH = 12'b1_0_0_1_10_00_10_0_0;
  localparam logic [11:0] V_DEC   = 12'b0_0_0_0_00_01_01_0_0;
  localparam logic [11:0] V_DECIL = 12'b0_0_0_0_00_01_01_0_1;
  localparam logic [11:0] V_RS1I  = 12'b0_0_0_0_00_10_01_0_0;
  localparam logic [11:0] V_MRD   = 12'b0_1_0_0_00_00_00_0_0;
  localparam logic [11:0] V_MWB   = 12'b0_0_0_0_01_00_00_1_0;
  localparam logic [11:0] V_MWR   = 12'b0_1_1_0_00_00_00_0_0;
  localparam logic [11:0] V_EXR   = 12'b0_0_0_0_00_10_00_0_0;
  localparam logic [11:0] V_AWB   = 12'b0_0_0_0_00_00_00_1_0;
  localparam logic [11:0] V_BRT   = 12'b1_0_0_0_00_10_00_0_0;
  localparam logic [11:0] V_JPC   = 12'b1_0_0_0_00_01_10_0_0;
  localparam logic [11:0] V_LUI   = 12'b0_0_0_0_00_11_01_0_0;
  localparam logic [11:0] V_Z     = 12'h000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] outv();
    return {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, RegWrite, Illegal};
  endfunction

  task automatic nxt();
    @(negedge clk); #1;
  endtask

  task automatic run(input string tag, input logic [6:0] o, input logic [2:0] f3,
                     input logic f7, input logic z, input logic lt, input logic ltu,
                     input int n, input logic [0:5][11:0] seq, input int alu_cyc,
                     input logic [3:0] alu_exp, input logic [2:0] imm_exp, input bit ret);
    op = o; funct3 = f3; funct7b5 = f7; Zero = z; Lt = lt; Ltu = ltu;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s.c%0d", tag, i + 1), {20'd0, outv()}, {20'd0, seq[i]});
      if (i == 0) chk({tag, ".instret"}, InstRet, exp_ret);
      if (i == 1) chk({tag, ".imm"}, {29'd0, ImmSrc}, {29'd0, imm_exp});
      if (i == alu_cyc) chk({tag, ".alu"}, {28'd0, ALUControl}, {28'd0, alu_exp});
      nxt();
    end
`ifdef MC_INSTRET_EN
    if (ret) exp_ret = exp_ret + 32'd1;
`endif
  endtask

  initial begin
    reset = 1'b0; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0;
    Zero = 1'b0; Lt = 1'b0; Ltu = 1'b0;
    #1;
    chk("rst.strobes", {27'd0, PCWrite, IRWrite, MemWrite, RegWrite, Illegal}, 32'd0);
    chk("rst.fetch_b", {30'd0, ALUSrcB}, 32'd2);
    chk("rst.instret", InstRet, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1; #1;

    run("lw",   7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 5,
        {V_FETCH, V_DEC, V_RS1I, V_MRD, V_MWB, V_Z}, 2, 4'd0, 3'd0, 1'b1);
    run("sw",   7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 4,
        {V_FETCH, V_DEC, V_RS1I, V_MWR, V_Z, V_Z}, 2, 4'd0, 3'd1, 1'b1);
    run("beq",  7'b1100011, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 3,
        {V_FETCH, V_DEC, V_BRT, V_Z, V_Z, V_Z}, 2, 4'd1, 3'd2, 1'b1);
    run("bne",  7'b1100011, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 3,
        {V_FETCH, V_DEC, V_EXR, V_Z, V_Z, V_Z}, 2, 4'd1, 3'd2, 1'b1);
    run("bgeu", 7'b1100011, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1, 3,
        {V_FETCH, V_DEC, V_EXR, V_Z, V_Z, V_Z}, 2, 4'd1, 3'd2, 1'b1);
    run("blt",  7'b1100011, 3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 3,
        {V_FETCH, V_DEC, V_BRT, V_Z, V_Z, V_Z}, 2, 4'd1, 3'd2, 1'b1);
    run("b010", 7'b1100011, 3'b010, 1'b0, 1'b1, 1'b1, 1'b1, 3,
        {V_FETCH, V_DEC, V_EXR, V_Z, V_Z, V_Z}, 2, 4'd1, 3'd2, 1'b1);
    run("sra",  7'b0110011, 3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 4,
        {V_FETCH, V_DEC, V_EXR, V_AWB, V_Z, V_Z}, 2, 4'd9, 3'd0, 1'b1);
    run("sub",  7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 4,
        {V_FETCH, V_DEC, V_EXR, V_AWB, V_Z, V_Z}, 2, 4'd1, 3'd0, 1'b1);
    run("sltu", 7'b0110011, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 4,
        {V_FETCH, V_DEC, V_EXR, V_AWB, V_Z, V_Z}, 2, 4'd6, 3'd0, 1'b1);
    run("addi", 7'b0010011, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 4,
        {V_FETCH, V_DEC, V_RS1I, V_AWB, V_Z, V_Z}, 2, 4'd0, 3'd0, 1'b1);
    run("srli", 7'b0010011, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 4,
        {V_FETCH, V_DEC, V_RS1I, V_AWB, V_Z, V_Z}, 2, 4'd8, 3'd0, 1'b1);
    run("andi", 7'b0010011, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 4,
        {V_FETCH, V_DEC, V_RS1I, V_AWB, V_Z, V_Z}, 2, 4'd2, 3'd0, 1'b1);
    run("jal",  7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 4,
        {V_FETCH, V_DEC, V_JPC, V_AWB, V_Z, V_Z}, 2, 4'd0, 3'd3, 1'b1);
    run("jalr", 7'b1100111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 5,
        {V_FETCH, V_DEC, V_RS1I, V_JPC, V_AWB, V_Z}, 3, 4'd0, 3'd0, 1'b1);
    run("lui",  7'b0110111, 3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 4,
        {V_FETCH, V_DEC, V_LUI, V_AWB, V_Z, V_Z}, 2, 4'd0, 3'd4, 1'b1);
    run("auipc",7'b0010111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 4,
        {V_FETCH, V_DEC, V_DEC, V_AWB, V_Z, V_Z}, 2, 4'd0, 3'd4, 1'b1);
    run("ill",  7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2,
        {V_FETCH, V_DECIL, V_Z, V_Z, V_Z, V_Z}, 1, 4'd0, 3'd0, 1'b0);

    // reset asserted during the MEMWRITE cycle of a store
    run("swr",  7'b0100011, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3,
        {V_FETCH, V_DEC, V_RS1I, V_Z, V_Z, V_Z}, 2, 4'd0, 3'd1, 1'b0);
    chk("swr.mw_before", {31'd0, MemWrite}, 32'd1);
    reset = 1'b0; #1;
    exp_ret = 32'd0;
    chk("swr.mw_rst", {27'd0, PCWrite, IRWrite, MemWrite, RegWrite, Illegal}, 32'd0);
    chk("swr.fetch_b", {30'd0, ALUSrcB}, 32'd2);
    chk("swr.instret", InstRet, 32'd0);
    nxt();
    chk("swr.hold", {30'd0, MemWrite, RegWrite}, 32'd0);
    @(negedge clk);
    reset = 1'b1; #1;

    run("post", 7'b0010011, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 4,
        {V_FETCH, V_DEC, V_RS1I, V_AWB, V_Z, V_Z}, 2, 4'd3, 3'd0, 1'b1);
    chk("end.fetch", {20'd0, outv()}, {20'd0, V_FETCH});
    chk("end.instret", InstRet, exp_ret);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
